tugemm_operand_loader: RTL and testbench

// - Upstream feeder for the tuGEMM 8x8 array. Accepts a byte-wide valid/ready stream of signed
//   8-bit elements and assembles one frame: 64 elements of A, then 64 elements of B, row-major.
// - Double-buffered: the next frame fills a staging buffer while the current operands stay

---
 rtl/tugemm_operand_loader_pkg.sv | 28 ++
 rtl/tugemm_operand_loader_if.sv | 34 +++
 rtl/tugemm_stage_buf.sv | 32 +++
 rtl/tugemm_operand_loader.sv | 144 ++++++++++++++
 tb/tb_tugemm_operand_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tugemm_operand_loader_pkg.sv
// Shared constants, FSM state type and packing helper for the tuGEMM operand loader.
// Contents:
//   N, DW, ELEMS  - matrix dimension, element width, elements per matrix
//   FRAME         - beats per frame (A then B)
//   VW            - packed width of one matrix
//   CW, AW        - beat counter width, staging address width
//   state_t       - loader FSM states {LOAD, WAIT}
//   elem_lsb(k)   - lsb position of element k inside a packed matrix vector
package tugemm_pkg;

  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int ELEMS = N * N;
  localparam int FRAME = 2 * ELEMS;
  localparam int VW    = ELEMS * DW;
  localparam int CW    = $clog2(FRAME);
  localparam int AW    = $clog2(ELEMS);

  typedef enum logic {
    LOAD = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic int elem_lsb(input int k);
    return DW * k;
  endfunction

endpackage

// File: rtl/tugemm_operand_loader_if.sv
// Handshake bundle between the element stream source, the operand loader and the
// GEMM controller.
// Signals:
//   in_valid/in_ready/in_data/in_last - byte stream into the loader
//   vector_a/vector_b                 - packed operand matrices out of the loader
//   op_valid/op_ready                 - operand pair handshake to the consumer
//   frame_err                         - one-cycle framing error pulse
// Modports:
//   slave  - loader side (consumes the stream, produces operands)
//   master - environment side (drives the stream, consumes operands)
interface tugemm_operand_loader_if;
  import tugemm_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [VW-1:0] vector_a;
  logic [VW-1:0] vector_b;
  logic          op_valid;
  logic          op_ready;
  logic          frame_err;

  modport slave (
    input  in_valid, in_data, in_last, op_ready,
    output in_ready, vector_a, vector_b, op_valid, frame_err
  );

  modport master (
    output in_valid, in_data, in_last, op_ready,
    input  in_ready, vector_a, vector_b, op_valid, frame_err
  );

endinterface

// File: rtl/tugemm_stage_buf.sv
// Byte-addressed staging register holding one N*N matrix while a frame is assembled.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset, clears the buffer
//   i_we    - write enable for one element
//   i_addr  - element index (row*N+col)
//   i_data  - element value, stored verbatim
//   o_data  - whole buffer, element k at bits [DW*k +: DW]
module tugemm_stage_buf
  import tugemm_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic [VW-1:0] o_data
);

  logic [VW-1:0] r_mem;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[elem_lsb(int'(i_addr)) +: DW] <= i_data;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/tugemm_operand_loader.sv
// Double-buffered operand loader: assembles a frame of A then B elements from a
// byte stream into staging buffers and hands complete operand pairs to the GEMM
// controller over op_valid/op_ready.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset
//   io_bus  - stream input, operand output and frame_err (slave modport)
//
// state | meaning
// LOAD  | accepting beats into staging
// WAIT  | staging full, output slot still occupied; stream stalled
module tugemm_operand_loader
  import tugemm_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  tugemm_operand_loader_if.slave  io_bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_live;
  logic          r_op_valid;
  logic          r_frame_err;
  logic [VW-1:0] r_vec_a;
  logic [VW-1:0] r_vec_b;

  logic [VW-1:0] w_stage_a;
  logic [VW-1:0] w_stage_b;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_cnt_last;
  logic          w_frame_done;
  logic          w_err;
  logic          w_we_a;
  logic          w_we_b;
  logic          w_xfer_load;
  logic          w_xfer_wait;

  // r_live keeps in_ready low until the first edge after reset release.
  assign w_in_ready   = r_live && (r_state == LOAD);
  assign w_accept     = io_bus.in_valid && w_in_ready;
  assign w_cnt_last   = (r_cnt == CW'(FRAME - 1));
  assign w_frame_done = w_accept && w_cnt_last && io_bus.in_last;
  // Misplaced in_last, or the final beat arriving without it.
  assign w_err        = w_accept && (io_bus.in_last != w_cnt_last);
  assign w_we_a       = w_accept && !r_cnt[CW-1];
  assign w_we_b       = w_accept &&  r_cnt[CW-1];

  tugemm_stage_buf u_stage_a (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we_a),
    .i_addr (r_cnt[AW-1:0]),
    .i_data (io_bus.in_data),
    .o_data (w_stage_a)
  );

  tugemm_stage_buf u_stage_b (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we_b),
    .i_addr (r_cnt[AW-1:0]),
    .i_data (io_bus.in_data),
    .o_data (w_stage_b)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer_load = 1'b0;
    w_xfer_wait = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_frame_done) begin
          if (!r_op_valid || io_bus.op_ready) begin
            w_xfer_load = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (io_bus.op_ready) begin
          w_xfer_wait = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_live      <= 1'b0;
      r_cnt       <= '0;
      r_op_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_vec_a     <= '0;
      r_vec_b     <= '0;
    end else begin
      r_live      <= 1'b1;
      r_frame_err <= w_err;

      if (w_frame_done || w_err) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end

      // On a direct transfer the final B element is still on in_data and not yet
      // in staging, so it is merged into the top byte here.
      if (w_xfer_load) begin
        r_vec_a <= w_stage_a;
        r_vec_b <= {io_bus.in_data, w_stage_b[VW-DW-1:0]};
      end else if (w_xfer_wait) begin
        r_vec_a <= w_stage_a;
        r_vec_b <= w_stage_b;
      end

      // A transfer on the same edge as consumption keeps op_valid high.
      if (w_xfer_load || w_xfer_wait) begin
        r_op_valid <= 1'b1;
      end else if (io_bus.op_ready) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.vector_a  = r_vec_a;
  assign io_bus.vector_b  = r_vec_b;
  assign io_bus.op_valid  = r_op_valid;
  assign io_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_tugemm_operand_loader.sv
module tb_tugemm_operand_loader;
  import tugemm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tugemm_operand_loader_if bus();

  tugemm_operand_loader dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int err_exp  = 0;
  int err_seen = 0;

  logic [DW-1:0]   fa [ELEMS];
  logic [DW-1:0]   fb [ELEMS];
  logic [2*VW-1:0] sb_q [$];
  logic            prev_valid = 1'b0;
  logic            prev_hs    = 1'b0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] btab(input int i);
    case (i % 8)
      0: return 8'd1;
      1: return 8'd2;
      2: return 8'd3;
      3: return 8'd2;
      4: return 8'd3;
      5: return 8'd4;
      6: return 8'd5;
      default: return 8'd4;
    endcase
  endfunction

  // kind 0: A=1..16 repeated, B=table; kind 1: kind 0 plus negatives;
  // kind 2: A=(3k)^5A, B=80+k; kind 3: A=255-k, B=7k
  task automatic fill(input int kind);
    for (int k = 0; k < ELEMS; k++) begin
      case (kind)
        0, 1: begin fa[k] = 8'((k % 16) + 1); fb[k] = btab(k); end
        2:    begin fa[k] = 8'(k * 3) ^ 8'h5A; fb[k] = 8'(8'h80 + k); end
        default: begin fa[k] = 8'(255 - k); fb[k] = 8'(k * 7); end
      endcase
    end
    if (kind == 1) begin
      fa[1]  = 8'hFF;
      fb[63] = 8'hD4;
    end
  endtask

  function automatic logic [2*VW-1:0] pack_frame();
    logic [2*VW-1:0] r;
    r = '0;
    for (int k = 0; k < ELEMS; k++) begin
      r[8*k +: 8]      = fa[k];
      r[VW + 8*k +: 8] = fb[k];
    end
    return r;
  endfunction

  task automatic send(input int nbeats, input int last_pos, input bit push, input bit rdy_on_last);
    bit ok;
    int guard;
    if (push) sb_q.push_back(pack_frame());
    for (int i = 0; i < nbeats; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < ELEMS) ? fa[i] : fb[i - ELEMS];
      bus.in_last  = (i == last_pos);
      if (rdy_on_last && i == nbeats - 1) bus.op_ready = 1'b1;
      guard = 0;
      do begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!ok && guard < 200);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout beat=%0d actual=0 required=1", i);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Scoreboard monitor: a frame is presented when op_valid is seen after being low
  // or after a handshake on the previous edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (bus.frame_err) err_seen++;
      if (bus.op_valid && (!prev_valid || prev_hs)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=presented required=none");
        end else begin
          logic [2*VW-1:0] exp;
          exp = sb_q.pop_front();
          chk("sb_vector_a", bus.vector_a, exp[VW-1:0]);
          chk("sb_vector_b", bus.vector_b, exp[2*VW-1:VW]);
        end
      end
      prev_valid = bus.op_valid;
      prev_hs    = bus.op_valid && bus.op_ready;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.op_ready = 1'b0;
    rst = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_op_valid", bus.op_valid, 1'b0);
    chk("rst_vector_a", bus.vector_a, '0);
    chk("rst_vector_b", bus.vector_b, '0);
    rst = 1'b0;
    #1;
    chk1("in_ready_at_release", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk1("in_ready_after_release", bus.in_ready, 1'b1);

    // positive frame, consumer not ready
    fill(0);
    send(128, 127, 1'b1, 1'b0);
    chk1("f1_op_valid", bus.op_valid, 1'b1);
    chk8("f1_a0", bus.vector_a[7:0], 8'h01);
    chk8("f1_a15", bus.vector_a[127:120], 8'h10);
    chk8("f1_b0", bus.vector_b[7:0], 8'h01);

    // negative values, completes under backpressure
    fill(1);
    send(128, 127, 1'b1, 1'b0);
    chk1("wait_in_ready", bus.in_ready, 1'b0);
    chk1("wait_op_valid", bus.op_valid, 1'b1);
    chk8("wait_a1_still_f1", bus.vector_a[15:8], 8'h02);
    repeat (3) @(posedge clk);
    #1;
    chk1("wait_hold_in_ready", bus.in_ready, 1'b0);
    bus.op_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
    chk1("f2_op_valid", bus.op_valid, 1'b1);
    chk1("f2_in_ready", bus.in_ready, 1'b1);
    chk8("f2_a1_neg", bus.vector_a[15:8], 8'hFF);
    chk8("f2_b63_neg", bus.vector_b[511:504], 8'hD4);

    // frame completes on the same edge the consumer takes the old one
    fill(2);
    send(128, 127, 1'b1, 1'b1);
    bus.op_ready = 1'b0;
    chk1("f3_no_bubble", bus.op_valid, 1'b1);
    chk8("f3_a0", bus.vector_a[7:0], 8'h5A);
    chk8("f3_b0", bus.vector_b[7:0], 8'h80);

    // drain the output slot
    bus.op_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
    chk1("drain_op_valid", bus.op_valid, 1'b0);

    // early in_last on beat 40
    fill(3);
    send(41, 40, 1'b0, 1'b0);
    err_exp++;
    chk1("err_early_pulse", bus.frame_err, 1'b1);
    @(posedge clk);
    #1;
    chk1("err_early_clear", bus.frame_err, 1'b0);
    chk1("err_early_op_valid", bus.op_valid, 1'b0);
    send(128, 127, 1'b1, 1'b0);
    chk1("f4_op_valid", bus.op_valid, 1'b1);
    chk8("f4_a0", bus.vector_a[7:0], 8'hFF);
    chk8("f4_b1", bus.vector_b[15:8], 8'h07);

    // beat 127 without in_last
    fill(0);
    send(128, -1, 1'b0, 1'b0);
    err_exp++;
    chk1("err_missing_pulse", bus.frame_err, 1'b1);
    chk1("err_missing_op_valid", bus.op_valid, 1'b1);
    chk8("err_missing_a0_kept", bus.vector_a[7:0], 8'hFF);

    // asynchronous reset mid-frame
    fill(2);
    send(70, -1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk1("async_op_valid", bus.op_valid, 1'b0);
    chk1("async_in_ready", bus.in_ready, 1'b0);
    chk("async_vector_a", bus.vector_a, '0);
    chk("async_vector_b", bus.vector_b, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill(1);
    send(128, 127, 1'b1, 1'b0);
    chk1("f5_op_valid", bus.op_valid, 1'b1);
    chk8("f5_a1", bus.vector_a[15:8], 8'hFF);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", VW'(sb_q.size()), '0);
    chk("frame_err_count", VW'(err_seen), VW'(err_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
